execute_stage_mc: RTL and testbench

Parametrised multi-cycle execute stage for the venus pipeline. It sits between decode/operand-fetch and writeback. It generalises the single-cycle execute stage in three ways: configurable datapath width, an iterative unsigned divider that stalls upstream while busy, and a sticky halt output in place of simulation termination. Single-cycle ALU ops, compare flags and load-result selection keep their existing pipeline semantics.

---
 rtl/execute_stage_mc.sv | 212 +++++++++++++++++++++
 tb/tb_execute_stage_mc.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage_mc.sv
// -----------------------------------------------------------------------------
// execute_stage_mc
//   Multi-cycle execute stage of the venus pipeline. Single-cycle ALU ops,
//   compare flags and load-result selection complete in one cycle; DIV runs
//   an iterative restoring unsigned divider that stalls upstream while busy.
//   HLT sets a sticky halt flag that only reset clears.
//
// Ports
//   clk, reset        clock, asynchronous active-low reset
//   v_i, stall_i      instruction valid, downstream stall
//   stall_o           upstream stall (stall_i or divider not idle)
//   opecode_i         opcode
//   opr0_i, opr1_i    operands
//   wb_i, wb_r_i      writeback enable / destination register
//   ldst_data_i       load data from memory (passed through for LD)
//   v_o, result_o     output valid / result
//   wb_o, wb_r_o      writeback enable (qualified by v_o) / destination
//   flags_o           {C,Z,S,V} from the last accepted CMP
//   busy_o            divider FSM not idle
//   halt_o            sticky halt
//
// Handshake: an instruction is accepted on a rising edge where
//   v_i & ~stall_o. While stall_i is high every output register holds.
// -----------------------------------------------------------------------------
module execute_stage_mc #(
    parameter int W_OPR = 32,
    parameter int W_OPC = 7,
    parameter int W_RD  = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             v_i,
    input  logic             stall_i,
    output logic             stall_o,
    input  logic [W_OPC-1:0] opecode_i,
    input  logic [W_OPR-1:0] opr0_i,
    input  logic [W_OPR-1:0] opr1_i,
    input  logic             wb_i,
    input  logic [W_RD-1:0]  wb_r_i,
    input  logic [W_OPR-1:0] ldst_data_i,
    output logic             v_o,
    output logic [W_OPR-1:0] result_o,
    output logic             wb_o,
    output logic [W_RD-1:0]  wb_r_o,
    output logic [3:0]       flags_o,
    output logic             busy_o,
    output logic             halt_o
);
    localparam int W_CNT = $clog2(W_OPR + 1);
    localparam logic [W_OPR-1:0] L_WIDTH = W_OPR'(W_OPR);

    localparam logic [W_OPC-1:0] OP_ADD = W_OPC'(7'h00);
    localparam logic [W_OPC-1:0] OP_SUB = W_OPC'(7'h01);
    localparam logic [W_OPC-1:0] OP_MUL = W_OPC'(7'h02);
    localparam logic [W_OPC-1:0] OP_DIV = W_OPC'(7'h03);
    localparam logic [W_OPC-1:0] OP_CMP = W_OPC'(7'h04);
    localparam logic [W_OPC-1:0] OP_ABS = W_OPC'(7'h05);
    localparam logic [W_OPC-1:0] OP_SHL = W_OPC'(7'h08);
    localparam logic [W_OPC-1:0] OP_SHR = W_OPC'(7'h09);
    localparam logic [W_OPC-1:0] OP_ASH = W_OPC'(7'h0A);
    localparam logic [W_OPC-1:0] OP_AND = W_OPC'(7'h10);
    localparam logic [W_OPC-1:0] OP_OR  = W_OPC'(7'h11);
    localparam logic [W_OPC-1:0] OP_NOT = W_OPC'(7'h12);
    localparam logic [W_OPC-1:0] OP_XOR = W_OPC'(7'h13);
    localparam logic [W_OPC-1:0] OP_HLT = W_OPC'(7'h1F);
    localparam logic [W_OPC-1:0] OP_LD  = W_OPC'(7'h40);

    typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_DONE} state_t;

    state_t             r_state;
    logic [W_CNT-1:0]   r_cnt;
    logic [W_OPR-1:0]   r_rem;
    logic [W_OPR-1:0]   r_quot;     // dividend bits shift out as quotient bits shift in
    logic [W_OPR-1:0]   r_dvs;
    logic               r_div_wb;
    logic [W_RD-1:0]    r_div_wb_r;

    logic               r_v;
    logic [W_OPR-1:0]   r_result;
    logic               r_wb;
    logic [W_RD-1:0]    r_wb_r;
    logic               r_ld;
    logic [3:0]         r_flags;
    logic               r_halt;

    logic               w_accept;
    logic [W_OPR-1:0]   w_sh;
    logic [W_OPR:0]     w_cmp;
    logic [3:0]         w_flags;
    logic [W_OPR-1:0]   w_alu;
    logic [W_OPR:0]     w_rem_sh;
    logic [W_OPR:0]     w_trial;

    assign stall_o  = stall_i | (r_state != IDLE);
    assign w_accept = v_i & ~stall_o;
    assign w_sh     = opr1_i % L_WIDTH;

    // opr0 + ~opr1 + 1 with the carry kept in the top bit
    assign w_cmp   = {1'b0, opr0_i} + {1'b0, ~opr1_i} + {{W_OPR{1'b0}}, 1'b1};
    assign w_flags = {w_cmp[W_OPR],
                      (w_cmp[W_OPR-1:0] == '0),
                      w_cmp[W_OPR-1],
                      (opr0_i[W_OPR-1] ^ opr1_i[W_OPR-1]) & (w_cmp[W_OPR-1] ^ opr0_i[W_OPR-1])};

    always_comb begin
        w_alu = '0;
        case (opecode_i)
            OP_ADD: w_alu = opr0_i + opr1_i;
            OP_SUB: w_alu = opr0_i - opr1_i;
            OP_MUL: w_alu = opr0_i * opr1_i;
            OP_CMP: w_alu = w_cmp[W_OPR-1:0];
            OP_ABS: w_alu = opr0_i[W_OPR-1] ? ('0 - opr0_i) : opr0_i;
            OP_SHL: w_alu = opr0_i << w_sh;
            OP_SHR: w_alu = opr0_i >> w_sh;
            OP_ASH: w_alu = $signed(opr0_i) >>> w_sh;
            OP_AND: w_alu = opr0_i & opr1_i;
            OP_OR:  w_alu = opr0_i | opr1_i;
            OP_NOT: w_alu = ~opr0_i;
            OP_XOR: w_alu = opr0_i ^ opr1_i;
            default: w_alu = '0;
        endcase
    end

    // Restoring step: the partial remainder stays below the divisor, so one
    // extra bit is enough to detect borrow. A zero divisor always "fits",
    // which yields an all-ones quotient without any special case.
    assign w_rem_sh = {r_rem, r_quot[W_OPR-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_dvs};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_dvs      <= '0;
            r_div_wb   <= 1'b0;
            r_div_wb_r <= '0;
            r_v        <= 1'b0;
            r_result   <= '0;
            r_wb       <= 1'b0;
            r_wb_r     <= '0;
            r_ld       <= 1'b0;
            r_flags    <= '0;
            r_halt     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept && opecode_i == OP_DIV) begin
                        r_state    <= DIV_RUN;
                        r_cnt      <= W_CNT'(W_OPR);
                        r_rem      <= '0;
                        r_quot     <= opr0_i;
                        r_dvs      <= opr1_i;
                        r_div_wb   <= wb_i;
                        r_div_wb_r <= wb_r_i;
                    end
                end
                DIV_RUN: begin
                    // iterations proceed regardless of stall_i
                    if (!w_trial[W_OPR]) begin
                        r_rem  <= w_trial[W_OPR-1:0];
                        r_quot <= {r_quot[W_OPR-2:0], 1'b1};
                    end else begin
                        r_rem  <= w_rem_sh[W_OPR-1:0];
                        r_quot <= {r_quot[W_OPR-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == W_CNT'(1)) r_state <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (!stall_i) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (!stall_i) begin
                case (r_state)
                    IDLE: begin
                        r_v <= w_accept && (opecode_i != OP_DIV);
                        if (w_accept) begin
                            r_result <= w_alu;
                            r_wb     <= wb_i;
                            r_wb_r   <= wb_r_i;
                            r_ld     <= (opecode_i == OP_LD);
                        end
                    end
                    DIV_DONE: begin
                        r_v      <= 1'b1;
                        r_result <= r_quot;
                        r_wb     <= r_div_wb;
                        r_wb_r   <= r_div_wb_r;
                        r_ld     <= 1'b0;
                    end
                    default: r_v <= 1'b0;   // bubble while dividing
                endcase
            end

            if (w_accept && opecode_i == OP_CMP) r_flags <= w_flags;
            if (w_accept && opecode_i == OP_HLT) r_halt  <= 1'b1;
        end
    end

    assign v_o      = r_v;
    assign result_o = r_ld ? ldst_data_i : r_result;
    assign wb_o     = r_wb & r_v;
    assign wb_r_o   = r_wb_r;
    assign flags_o  = r_flags;
    assign busy_o   = (r_state != IDLE);
    assign halt_o   = r_halt;

endmodule

// File: tb/tb_execute_stage_mc.sv
module tb_execute_stage_mc;
  localparam logic [6:0] OP_ADD = 7'h00, OP_SUB = 7'h01, OP_MUL = 7'h02, OP_DIV = 7'h03;
  localparam logic [6:0] OP_CMP = 7'h04, OP_ABS = 7'h05, OP_SHL = 7'h08, OP_SHR = 7'h09;
  localparam logic [6:0] OP_ASH = 7'h0A, OP_AND = 7'h10, OP_OR = 7'h11, OP_NOT = 7'h12;
  localparam logic [6:0] OP_XOR = 7'h13, OP_HLT = 7'h1F, OP_LD = 7'h40;

  logic        clk;
  logic        reset;
  logic        v_i;
  logic        stall_i;
  logic        stall_o;
  logic [6:0]  opecode_i;
  logic [31:0] opr0_i;
  logic [31:0] opr1_i;
  logic        wb_i;
  logic [4:0]  wb_r_i;
  logic [31:0] ldst_data_i;
  logic        v_o;
  logic [31:0] result_o;
  logic        wb_o;
  logic [4:0]  wb_r_o;
  logic [3:0]  flags_o;
  logic        busy_o;
  logic        halt_o;

  int n_cmp = 0;
  int n_err = 0;
  // {wb, wb_r, result}
  logic [37:0] exp_q[$];

  execute_stage_mc #(.W_OPR(32), .W_OPC(7), .W_RD(5)) dut (
    .clk(clk), .reset(reset), .v_i(v_i), .stall_i(stall_i), .stall_o(stall_o),
    .opecode_i(opecode_i), .opr0_i(opr0_i), .opr1_i(opr1_i), .wb_i(wb_i),
    .wb_r_i(wb_r_i), .ldst_data_i(ldst_data_i), .v_o(v_o), .result_o(result_o),
    .wb_o(wb_o), .wb_r_o(wb_r_o), .flags_o(flags_o), .busy_o(busy_o), .halt_o(halt_o)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] opc, input logic [31:0] a, input logic [31:0] b,
                       input logic push, input logic [31:0] exp);
    logic       wb;
    logic [4:0] rd;
    wb = 1'($urandom_range(0, 1));
    rd = 5'($urandom_range(0, 31));
    v_i = 1'b1;
    opecode_i = opc;
    opr0_i = a;
    opr1_i = b;
    wb_i = wb;
    wb_r_i = rd;
    if (push) exp_q.push_back({wb, rd, exp});
  endtask

  // scoreboard: an output beat must be valid and match the oldest expectation
  task automatic expect_valid(input string tag);
    logic [37:0] e;
    check({tag, " v_o"}, 32'(v_o), 32'd1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: output observed %h with expected queue empty", tag, result_o);
    end else begin
      e = exp_q.pop_front();
      check({tag, " result"}, result_o, e[31:0]);
      check({tag, " wb_o"}, 32'(wb_o), 32'(e[37]));
      check({tag, " wb_r_o"}, 32'(wb_r_o), 32'(e[36:32]));
    end
  endtask

  task automatic run_op(input string tag, input logic [6:0] opc, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    drive(opc, a, b, 1'b1, exp);
    tick();
    expect_valid(tag);
  endtask

  // waits (bounded) for the next valid beat and checks its latency in edges
  task automatic wait_valid(input string tag, input int exp_lat);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!v_o && n < 60);
    check({tag, " latency"}, 32'(n), 32'(exp_lat));
    expect_valid(tag);
  endtask

  initial begin
    reset = 1'b0;
    v_i = 1'b0;
    stall_i = 1'b0;
    opecode_i = OP_ADD;
    opr0_i = '0;
    opr1_i = '0;
    wb_i = 1'b0;
    wb_r_i = '0;
    ldst_data_i = 32'hDEAD_BEEF;
    repeat (2) tick();

    // reset state
    check("rst v_o", 32'(v_o), 32'd0);
    check("rst result_o", result_o, 32'd0);
    check("rst wb_o", 32'(wb_o), 32'd0);
    check("rst wb_r_o", 32'(wb_r_o), 32'd0);
    check("rst flags_o", 32'(flags_o), 32'd0);
    check("rst busy_o", 32'(busy_o), 32'd0);
    check("rst halt_o", 32'(halt_o), 32'd0);
    check("rst stall_o lo", 32'(stall_o), 32'd0);
    stall_i = 1'b1;
    #1;
    check("rst stall_o hi", 32'(stall_o), 32'd1);
    stall_i = 1'b0;
    #1;
    reset = 1'b1;

    // single-cycle ops, issued back to back
    run_op("add", OP_ADD, 32'd5, 32'd7, 32'd12);
    check("add flags_o", 32'(flags_o), 32'd0);
    check("add halt_o", 32'(halt_o), 32'd0);
    run_op("sub", OP_SUB, 32'd5, 32'd7, 32'hFFFF_FFFE);
    run_op("mul", OP_MUL, 32'h0001_0000, 32'h0001_0003, 32'h0003_0000);
    run_op("and", OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
    run_op("or", OP_OR, 32'h0000_F0F0, 32'h0000_0F00, 32'h0000_FFF0);
    run_op("xor", OP_XOR, 32'h0000_FF00, 32'h0000_0FF0, 32'h0000_F0F0);
    run_op("not", OP_NOT, 32'h0000_FFFF, 32'd0, 32'hFFFF_0000);
    run_op("shl mod", OP_SHL, 32'd1, 32'd33, 32'd2);
    run_op("shr", OP_SHR, 32'h8000_0000, 32'd4, 32'h0800_0000);
    run_op("ash", OP_ASH, 32'h8000_0000, 32'd4, 32'hF800_0000);
    run_op("abs", OP_ABS, 32'hFFFF_FFF6, 32'd0, 32'd10);
    run_op("add wrap", OP_ADD, 32'hFFFF_FFFF, 32'd2, 32'd1);
    run_op("undef op", 7'h07, 32'd5, 32'd6, 32'd0);

    // load pass-through is combinational from ldst_data_i
    ldst_data_i = 32'h1234_5678;
    run_op("ld", OP_LD, 32'd0, 32'd0, 32'h1234_5678);
    ldst_data_i = 32'hCAFE_F00D;
    #1;
    check("ld passthru", result_o, 32'hCAFE_F00D);
    v_i = 1'b0;
    tick();
    check("bubble v_o", 32'(v_o), 32'd0);

    // downstream stall holds the output registers and blocks acceptance
    run_op("add pre-stall", OP_ADD, 32'd20, 32'd22, 32'd42);
    stall_i = 1'b1;
    drive(OP_ADD, 32'd1, 32'd1, 1'b1, 32'd2);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stall hold v_o", 32'(v_o), 32'd1);
      check("stall hold result", result_o, 32'd42);
      check("stall stall_o", 32'(stall_o), 32'd1);
    end
    stall_i = 1'b0;
    tick();
    expect_valid("add post-stall");
    v_i = 1'b0;

    // compare flags
    run_op("cmp 3,5", OP_CMP, 32'd3, 32'd5, 32'hFFFF_FFFE);
    check("cmp 3,5 flags", 32'(flags_o), 32'b0010);
    run_op("cmp ovf", OP_CMP, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF);
    check("cmp ovf flags", 32'(flags_o), 32'b1001);
    run_op("add keep flags", OP_ADD, 32'd3, 32'd4, 32'd7);
    check("flags kept", 32'(flags_o), 32'b1001);

    // DIV 100/7 with an ADD waiting behind it
    drive(OP_DIV, 32'd100, 32'd7, 1'b1, 32'd14);
    tick();
    drive(OP_ADD, 32'd1, 32'd2, 1'b1, 32'd3);
    for (int k = 0; k < 33; k++) begin
      check("div stall_o", 32'(stall_o), 32'd1);
      check("div v_o low", 32'(v_o), 32'd0);
      if (k < 32) tick();
    end
    tick();
    expect_valid("div 100/7");
    check("div busy_o done", 32'(busy_o), 32'd0);
    check("div stall_o done", 32'(stall_o), 32'd0);
    tick();
    expect_valid("add after div");
    v_i = 1'b0;

    // divide by zero
    drive(OP_DIV, 32'd9, 32'd0, 1'b1, 32'hFFFF_FFFF);
    tick();
    v_i = 1'b0;
    wait_valid("div 9/0", 33);

    // stall during iterations and through DIV_DONE
    drive(OP_DIV, 32'd100, 32'd7, 1'b1, 32'd14);
    tick();
    v_i = 1'b0;
    repeat (20) tick();
    stall_i = 1'b1;
    repeat (12) tick();
    check("div done busy_o", 32'(busy_o), 32'd1);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("div done v_o", 32'(v_o), 32'd0);
      check("div done stall_o", 32'(stall_o), 32'd1);
    end
    stall_i = 1'b0;
    #1;
    check("div done stall_o fsm", 32'(stall_o), 32'd1);
    tick();
    expect_valid("div stalled");

    // reset mid-division
    drive(OP_DIV, 32'd100, 32'd7, 1'b1, 32'd14);
    tick();
    v_i = 1'b0;
    repeat (10) tick();
    check("mid-div busy_o", 32'(busy_o), 32'd1);
    reset = 1'b0;
    #1;
    check("reset busy_o", 32'(busy_o), 32'd0);
    check("reset stall_o", 32'(stall_o), 32'd0);
    check("reset v_o", 32'(v_o), 32'd0);
    check("reset flags_o", 32'(flags_o), 32'd0);
    exp_q.delete();
    #1;
    reset = 1'b1;
    run_op("add after reset", OP_ADD, 32'd1, 32'd1, 32'd2);

    // halt
    v_i = 1'b0;
    opecode_i = OP_HLT;
    tick();
    check("hlt invalid", 32'(halt_o), 32'd0);
    run_op("hlt", OP_HLT, 32'd0, 32'd0, 32'd0);
    check("hlt set", 32'(halt_o), 32'd1);
    run_op("add after hlt", OP_ADD, 32'd2, 32'd3, 32'd5);
    check("hlt sticky", 32'(halt_o), 32'd1);
    v_i = 1'b0;
    tick();
    check("final v_o", 32'(v_o), 32'd0);
    check("final halt", 32'(halt_o), 32'd1);
    check("queue drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
